// File: rtl/tag_allocator_mc_pkg.sv
// Shared helpers for the multi-channel tag allocator.
// Contents:
//   ch_bits_f : owner-index width for a given channel count (at least 1 bit)
//   tags_f    : tag pool size for a given tag width
package tag_allocator_mc_pkg;

  // Owner index width; a single channel still needs a 1-bit field.
  function automatic int ch_bits_f(input int nch);
    int w;
    if (nch <= 1) begin
      w = 1;
    end else begin
      w = $clog2(nch);
    end
    return w;
  endfunction

  // Number of tags addressable by a tag of the given width.
  function automatic int tags_f(input int tag_bits);
    return 32'sd1 << tag_bits;
  endfunction

endpackage

// File: rtl/tag_allocator_mc_if.sv
// Handshake bundle between the tag allocator and its clients.
// Signals:
//   alloc_req          per-channel level request
//   m_tag_alloc_data   granted tag
//   m_tag_alloc_valid  one-hot valid towards the granted channel
//   m_tag_alloc_ready  per-channel ready
//   s_tag_free_data    tag being returned
//   s_tag_free_valid   free strobe
//   s_tag_free_ready   allocator accepts frees
// Modports: master = allocator side, slave = channel / completion side.
interface tag_allocator_mc_if #(
  parameter int PCIE_TAG_BITS = 5,
  parameter int NCH           = 2
);
  logic [NCH-1:0]           alloc_req;
  logic [PCIE_TAG_BITS-1:0] m_tag_alloc_data;
  logic [NCH-1:0]           m_tag_alloc_valid;
  logic [NCH-1:0]           m_tag_alloc_ready;
  logic [PCIE_TAG_BITS-1:0] s_tag_free_data;
  logic                     s_tag_free_valid;
  logic                     s_tag_free_ready;

  modport master (
    input  alloc_req,
    input  m_tag_alloc_ready,
    input  s_tag_free_data,
    input  s_tag_free_valid,
    output m_tag_alloc_data,
    output m_tag_alloc_valid,
    output s_tag_free_ready
  );

  modport slave (
    output alloc_req,
    output m_tag_alloc_ready,
    output s_tag_free_data,
    output s_tag_free_valid,
    input  m_tag_alloc_data,
    input  m_tag_alloc_valid,
    input  s_tag_free_ready
  );
endinterface

// File: rtl/tag_allocator_mc_rr_arbiter.sv
// Round-robin arbiter over NCH eligible requesters.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   req         eligibility mask (already qualified by the caller)
//   en          advance the pointer past the current winner
//   grant_oh    one-hot winner (all zero when nothing is eligible)
//   grant_idx   binary winner index (0 when nothing is eligible)
// The search starts at the pointer and wraps; the pointer moves to
// winner+1 only when the caller actually consumes the grant.
module tag_allocator_mc_rr_arbiter #(
  parameter int NCH     = 2,
  parameter int CH_BITS = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH-1:0]     req,
  input  logic               en,
  output logic [NCH-1:0]     grant_oh,
  output logic [CH_BITS-1:0] grant_idx
);

  logic [CH_BITS-1:0] ptr_r;

  // Rotating search for the first eligible channel at or after the pointer.
  always_comb begin
    int  idx_v;
    logic found_v;
    grant_oh  = '0;
    grant_idx = '0;
    found_v   = 1'b0;
    idx_v     = 0;
    for (int k = 0; k < NCH; k++) begin
      idx_v = (int'(ptr_r) + k) % NCH;
      if (!found_v && req[idx_v]) begin
        found_v          = 1'b1;
        grant_oh[idx_v]  = 1'b1;
        grant_idx        = CH_BITS'(idx_v);
      end else begin
        found_v = found_v;
      end
    end
  end

  // Pointer register: winner+1 modulo NCH on a consumed grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (en) begin
      if (grant_idx == CH_BITS'(NCH - 1)) begin
        ptr_r <= '0;
      end else begin
        ptr_r <= grant_idx + CH_BITS'(1);
      end
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/tag_allocator_mc.sv
// Multi-channel PCIe tag allocator built around a free-tag bitmap.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus (master)    alloc request/grant and free handshakes
//   core_ready      allocator operational (first edge after reset release)
//   notags          free bitmap empty
//   tags_used       number of tags not in the free bitmap
//   ch_outstanding  per-channel reserved+outstanding counts, ch0 in LSBs
//   err_double_free sticky flag for frees of free or still-held tags
//   err_clr         clears err_double_free (a same-cycle error wins)
// A tag is reserved into a one-entry holding register (HR) when it is
// chosen, so the bitmap, owner table and counts change at load time, not
// at handshake time. The HR holds steady until its handshake completes.
module tag_allocator_mc
  import tag_allocator_mc_pkg::*;
#(
  parameter int PCIE_TAG_BITS = 5,
  parameter int NCH           = 2,
  parameter int MAX_PER_CH    = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  tag_allocator_mc_if.master               bus,
  output logic                             core_ready,
  output logic                             notags,
  output logic [PCIE_TAG_BITS:0]           tags_used,
  output logic [NCH*(PCIE_TAG_BITS+1)-1:0] ch_outstanding,
  output logic                             err_double_free,
  input  logic                             err_clr
);

  localparam int TB      = PCIE_TAG_BITS;
  localparam int CW      = PCIE_TAG_BITS + 1;
  localparam int TAGS    = tags_f(PCIE_TAG_BITS);
  localparam int CH_BITS = ch_bits_f(NCH);
  localparam logic [CW-1:0] MAX_C  = CW'(MAX_PER_CH);
  localparam logic [CW-1:0] TAGS_C = CW'(TAGS);

  // State
  logic                core_ready_r;
  logic [TAGS-1:0]     free_bm_r;
  logic [CH_BITS-1:0]  owner_r [TAGS];
  logic [CW-1:0]       cnt_r [NCH];
  logic                hr_valid_r;
  logic [NCH-1:0]      valid_oh_r;
  logic [TB-1:0]       hr_tag_r;
  logic [CW-1:0]       tags_used_r;
  logic                notags_r;
  logic                err_r;

  // Combinational
  logic                hs_s;
  logic [NCH-1:0]      elig_s;
  logic                any_free_s;
  logic [TB-1:0]       low_tag_s;
  logic                load_s;
  logic [NCH-1:0]      grant_oh_s;
  logic [CH_BITS-1:0]  grant_idx_s;
  logic                free_acc_s;
  logic                free_in_hr_s;
  logic                free_ok_s;
  logic                free_err_s;
  logic [CH_BITS-1:0]  free_owner_s;
  logic [TAGS-1:0]     bm_nxt_s;
  logic [CW-1:0]       cnt_nxt_s [NCH];
  logic [CW-1:0]       used_nxt_s;

  // Lowest-index free tag; scanning downwards lets the lowest hit win.
  always_comb begin
    low_tag_s  = '0;
    any_free_s = 1'b0;
    for (int i = TAGS - 1; i >= 0; i--) begin
      if (free_bm_r[i]) begin
        low_tag_s  = TB'(i);
        any_free_s = 1'b1;
      end else begin
        any_free_s = any_free_s;
      end
    end
  end

  // Channel eligibility: requesting and below its outstanding limit.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < NCH; i++) begin
      elig_s[i] = bus.alloc_req[i] & (cnt_r[i] < MAX_C);
    end
  end

  tag_allocator_mc_rr_arbiter #(
    .NCH     (NCH),
    .CH_BITS (CH_BITS)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (elig_s),
    .en        (load_s),
    .grant_oh  (grant_oh_s),
    .grant_idx (grant_idx_s)
  );

  // Handshake, load decision and free classification. The load looks at
  // the pre-free bitmap, so a freed tag is never the tag loaded this cycle.
  always_comb begin
    hs_s         = |(valid_oh_r & bus.m_tag_alloc_ready);
    load_s       = core_ready_r & any_free_s & (|elig_s) & (~hr_valid_r | hs_s);
    free_acc_s   = bus.s_tag_free_valid & core_ready_r;
    free_in_hr_s = hr_valid_r & (hr_tag_r == bus.s_tag_free_data);
    free_ok_s    = free_acc_s & ~free_bm_r[bus.s_tag_free_data] & ~free_in_hr_s;
    free_err_s   = free_acc_s & ~free_ok_s;
    free_owner_s = owner_r[bus.s_tag_free_data];
  end

  // Next bitmap, per-channel counts and used total from load/free deltas.
  always_comb begin
    bm_nxt_s = free_bm_r;
    if (load_s) begin
      bm_nxt_s[low_tag_s] = 1'b0;
    end else begin
      bm_nxt_s = bm_nxt_s;
    end
    if (free_ok_s) begin
      bm_nxt_s[bus.s_tag_free_data] = 1'b1;
    end else begin
      bm_nxt_s = bm_nxt_s;
    end
    for (int i = 0; i < NCH; i++) begin
      cnt_nxt_s[i] = cnt_r[i]
                   + CW'(load_s & (grant_idx_s == CH_BITS'(i)))
                   - CW'(free_ok_s & (free_owner_s == CH_BITS'(i)));
    end
    used_nxt_s = tags_used_r + CW'(load_s) - CW'(free_ok_s);
  end

  // Allocator state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_ready_r <= 1'b0;
      free_bm_r    <= '1;
      for (int i = 0; i < TAGS; i++) begin
        owner_r[i] <= '0;
      end
      for (int i = 0; i < NCH; i++) begin
        cnt_r[i] <= '0;
      end
      hr_valid_r   <= 1'b0;
      valid_oh_r   <= '0;
      hr_tag_r     <= '0;
      tags_used_r  <= '0;
      notags_r     <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      core_ready_r <= 1'b1;
      free_bm_r    <= bm_nxt_s;
      for (int i = 0; i < NCH; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
      tags_used_r  <= used_nxt_s;
      notags_r     <= (used_nxt_s == TAGS_C);
      err_r        <= free_err_s | (err_r & ~err_clr);
      if (load_s) begin
        owner_r[low_tag_s] <= grant_idx_s;
        hr_valid_r         <= 1'b1;
        valid_oh_r         <= grant_oh_s;
        hr_tag_r           <= low_tag_s;
      end else if (hs_s) begin
        hr_valid_r <= 1'b0;
        valid_oh_r <= '0;
      end else begin
        hr_valid_r <= hr_valid_r;
        valid_oh_r <= valid_oh_r;
      end
    end
  end

  assign core_ready            = core_ready_r;
  assign notags                = notags_r;
  assign tags_used             = tags_used_r;
  assign err_double_free       = err_r;
  assign bus.m_tag_alloc_data  = hr_tag_r;
  assign bus.m_tag_alloc_valid = valid_oh_r;
  assign bus.s_tag_free_ready  = core_ready_r;

  for (genvar g = 0; g < NCH; g++) begin : g_cnt_out
    assign ch_outstanding[g*CW +: CW] = cnt_r[g];
  end

endmodule

// File: tb/tb_tag_allocator_mc.sv
// Self-checking bench for tag_allocator_mc: directed steps followed by a
// randomized phase, all checked against a transaction-level model.
module tb_tag_allocator_mc;

  localparam int TB   = 5;
  localparam int NCH  = 2;
  localparam int MAX  = 20;
  localparam int TAGS = 1 << TB;
  localparam int CW   = TB + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_clr = 1'b0;
  logic core_ready, notags, err_double_free;
  logic [TB:0] tags_used;
  logic [NCH*CW-1:0] ch_outstanding;

  int checks = 0;
  int errors = 0;

  tag_allocator_mc_if #(.PCIE_TAG_BITS(TB), .NCH(NCH)) bus ();

  tag_allocator_mc #(.PCIE_TAG_BITS(TB), .NCH(NCH), .MAX_PER_CH(MAX)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .core_ready      (core_ready),
    .notags          (notags),
    .tags_used       (tags_used),
    .ch_outstanding  (ch_outstanding),
    .err_double_free (err_double_free),
    .err_clr         (err_clr)
  );

  always #5 clk = ~clk;

  // Reference model: set of free tags, owner of each tag, per-channel
  // counts, the one pending grant, round-robin start and the error flag.
  bit m_free [TAGS];
  int m_owner [TAGS];
  int m_cnt [NCH];
  bit m_hv;
  int m_ht, m_hc, m_rr;
  bit m_err, m_cr;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < TAGS; i++) begin
      m_free[i] = 1'b1;
      m_owner[i] = 0;
    end
    for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
    m_hv = 0; m_ht = 0; m_hc = 0; m_rr = 0; m_err = 0; m_cr = 0;
  endtask

  task automatic model_edge();
    bit hs, load, fok, ferr;
    int t, w, c, fd;
    if (!m_cr) begin
      m_cr = 1;
      return;
    end
    hs = m_hv && bus.m_tag_alloc_ready[m_hc];
    t = -1;
    for (int i = 0; i < TAGS; i++) if (m_free[i]) begin t = i; break; end
    w = -1;
    for (int k = 0; k < NCH; k++) begin
      c = (m_rr + k) % NCH;
      if (bus.alloc_req[c] && m_cnt[c] < MAX) begin w = c; break; end
    end
    load = (t >= 0) && (w >= 0) && (!m_hv || hs);
    fok = 0; ferr = 0; fd = int'(bus.s_tag_free_data);
    if (bus.s_tag_free_valid) begin
      if (m_free[fd] || (m_hv && m_ht == fd)) ferr = 1;
      else fok = 1;
    end
    if (ferr) m_err = 1;
    else if (err_clr) m_err = 0;
    if (fok) begin
      m_free[fd] = 1;
      m_cnt[m_owner[fd]]--;
    end
    if (hs) m_hv = 0;
    if (load) begin
      m_free[t] = 0; m_owner[t] = w; m_cnt[w]++;
      m_hv = 1; m_ht = t; m_hc = w; m_rr = (w + 1) % NCH;
    end
  endtask

  task automatic check_all();
    int used;
    logic [NCH*CW-1:0] e;
    used = 0;
    for (int i = 0; i < TAGS; i++) if (!m_free[i]) used++;
    for (int i = 0; i < NCH; i++) begin
      e[i*CW +: CW] = CW'(m_cnt[i]);
      chk("model_cnt_bound", 64'(m_cnt[i] >= 0 && m_cnt[i] <= MAX), 64'd1);
    end
    chk("model_used_bound", 64'(used <= TAGS), 64'd1);
    chk("core_ready", 64'(core_ready), 64'(m_cr));
    chk("free_ready", 64'(bus.s_tag_free_ready), 64'(m_cr));
    chk("valid", 64'(bus.m_tag_alloc_valid), m_hv ? (64'd1 << m_hc) : 64'd0);
    if (m_hv) chk("data", 64'(bus.m_tag_alloc_data), 64'(m_ht));
    chk("tags_used", 64'(tags_used), 64'(used));
    chk("notags", 64'(notags), 64'(used == TAGS));
    chk("ch_outstanding", 64'(ch_outstanding), 64'(e));
    chk("err", 64'(err_double_free), 64'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_in(input logic [NCH-1:0] req, input logic [NCH-1:0] rdy,
                        input logic fv, input int fd, input logic clr);
    bus.alloc_req = req;
    bus.m_tag_alloc_ready = rdy;
    bus.s_tag_free_valid = fv;
    bus.s_tag_free_data = TB'(fd);
    err_clr = clr;
  endtask

  initial begin
    int fd, st, t;
    set_in(2'b00, 2'b00, 1'b0, 0, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    chk("reset_data", 64'(bus.m_tag_alloc_data), 64'd0);
    rst_n = 1'b1;

    // ch0 alone: tags 0..MAX-1 in order, then its limit stops it.
    set_in(2'b01, 2'b11, 1'b0, 0, 1'b0);
    step();
    chk("ready_first_edge", 64'(core_ready), 64'd1);
    for (int i = 0; i < MAX; i++) begin
      step();
      chk("seq_tag_ch0", 64'(bus.m_tag_alloc_data), 64'(i));
      chk("seq_valid_ch0", 64'(bus.m_tag_alloc_valid), 64'd1);
    end
    step();
    step();
    chk("limit_no_valid", 64'(bus.m_tag_alloc_valid), 64'd0);
    chk("limit_count", 64'(ch_outstanding[CW-1:0]), 64'(MAX));

    // ch1 takes the rest of the pool until it runs dry.
    set_in(2'b11, 2'b11, 1'b0, 0, 1'b0);
    for (int i = MAX; i < TAGS; i++) begin
      step();
      chk("seq_tag_ch1", 64'(bus.m_tag_alloc_data), 64'(i));
      chk("seq_valid_ch1", 64'(bus.m_tag_alloc_valid), 64'd2);
    end
    step();
    chk("pool_notags", 64'(notags), 64'd1);
    chk("pool_used", 64'(tags_used), 64'(TAGS));

    // Double free of tag 7, then clear, then tag 7 is granted next.
    set_in(2'b00, 2'b11, 1'b1, 7, 1'b0);
    step();
    chk("free7_used", 64'(tags_used), 64'(TAGS - 1));
    step();
    chk("dbl_err", 64'(err_double_free), 64'd1);
    chk("dbl_used", 64'(tags_used), 64'(TAGS - 1));
    set_in(2'b00, 2'b11, 1'b0, 0, 1'b1);
    step();
    chk("err_clr", 64'(err_double_free), 64'd0);
    set_in(2'b01, 2'b11, 1'b0, 0, 1'b0);
    step();
    chk("regrant7", 64'(bus.m_tag_alloc_data), 64'd7);
    set_in(2'b00, 2'b11, 1'b0, 0, 1'b0);
    step();

    // Stall: grant of tag 3 held 5 cycles with request dropped.
    set_in(2'b00, 2'b11, 1'b1, 3, 1'b0);
    step();
    set_in(2'b01, 2'b00, 1'b0, 0, 1'b0);
    step();
    set_in(2'b00, 2'b00, 1'b0, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_tag", 64'(bus.m_tag_alloc_data), 64'd3);
      chk("stall_valid", 64'(bus.m_tag_alloc_valid), 64'd1);
    end
    set_in(2'b00, 2'b01, 1'b0, 0, 1'b0);
    step();
    chk("stall_done", 64'(bus.m_tag_alloc_valid), 64'd0);
    chk("stall_count", 64'(ch_outstanding[CW-1:0]), 64'(MAX));

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      fd = int'($urandom_range(0, TAGS - 1));
      if ($urandom_range(0, 9) < 8) begin
        st = fd;
        for (int k = 0; k < TAGS; k++) begin
          t = (st + k) % TAGS;
          if (!m_free[t] && !(m_hv && m_ht == t)) begin fd = t; break; end
        end
      end
      set_in(NCH'($urandom_range(0, 3)), NCH'($urandom_range(0, 3) | $urandom_range(0, 3)),
             1'($urandom_range(0, 9) < 4), fd, 1'($urandom_range(0, 19) == 0));
      step();
    end

    // Partial-cycle reset mid-stream, then alternating grants from tag 0.
    set_in(2'b11, 2'b11, 1'b0, 0, 1'b0);
    step();
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("midrst_data", 64'(bus.m_tag_alloc_data), 64'd0);
    #1 rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_tag", 64'(bus.m_tag_alloc_data), 64'(i));
      chk("rr_valid", 64'(bus.m_tag_alloc_valid), 64'd1 << (i % 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
